// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StRead      = 4'd1,
        StReadMiss  = 4'd2,
        StReadMem   = 4'd3,
        StReadData  = 4'd4,
        StWrite     = 4'd5,
        StWriteHit  = 4'd6,
        StWriteMiss = 4'd7,
        StWriteMem  = 4'd8,
        StWriteData = 4'd9
    } state_e;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SEL_CACHE = 1'b0;
    localparam logic SEL_MEM   = 1'b1;

    function automatic int unsigned ctr_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_lat_counter.sv
// Memory-latency wait counter: loads a start value, counts down to zero and holds there.
module lat_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: sequences read/write hit and miss handling against main memory.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 4,
    parameter int unsigned WRITE_ALLOC = 0,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe_i,
    input  logic              rw_i,
    input  logic              m_i,
    input  logic              v_i,
`ifdef CACHE_STATS_EN
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] rd_hit_cnt_o,
    output logic [STAT_W-1:0] rd_miss_cnt_o,
    output logic [STAT_W-1:0] wr_hit_cnt_o,
    output logic [STAT_W-1:0] wr_miss_cnt_o,
`endif
    output logic              busy_o,
    output logic              rdy_o,
    output logic              w_o,
    output logic              w_sel_o,
    output logic              r_sel_o,
    output logic              m_strobe_o,
    output logic              m_rw_o
);

    localparam int unsigned CtrW = ctr_width(MEM_LAT);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("cache_ctrl_fsm: MEM_LAT must be >= 1");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("cache_ctrl_fsm: STAT_W must be >= 1");
    end

    state_e state_q, state_d;
    logic   hit;
    logic   ctr_load, ctr_dec, ctr_zero;

    assign hit = m_i & v_i;

    lat_counter #(
        .WIDTH (CtrW)
    ) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load),
        .load_val_i (CtrW'(MEM_LAT - 1)),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b0;
        rdy_o      = 1'b0;
        w_o        = 1'b0;
        w_sel_o    = SEL_CACHE;
        r_sel_o    = SEL_CACHE;
        m_strobe_o = 1'b0;
        m_rw_o     = RW_READ;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        case (state_q)
            StIdle: begin
                if (strobe_i) begin
                    state_d = (rw_i == RW_WRITE) ? StWrite : StRead;
                end
            end
            StRead: begin
                busy_o = 1'b1;
                if (hit) begin
                    rdy_o   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StReadMiss;
                end
            end
            StReadMiss: begin
                busy_o     = 1'b1;
                m_strobe_o = 1'b1;
                ctr_load   = 1'b1;
                state_d    = StReadMem;
            end
            StReadMem: begin
                busy_o = 1'b1;
                if (ctr_zero) begin
                    state_d = StReadData;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StReadData: begin
                busy_o  = 1'b1;
                w_o     = 1'b1;
                w_sel_o = SEL_MEM;
                r_sel_o = SEL_MEM;
                rdy_o   = 1'b1;
                state_d = StIdle;
            end
            StWrite: begin
                busy_o  = 1'b1;
                state_d = hit ? StWriteHit : StWriteMiss;
            end
            StWriteHit, StWriteMiss: begin
                busy_o     = 1'b1;
                // Write-around leaves the line untouched on a miss.
                w_o        = (state_q == StWriteHit) || (WRITE_ALLOC != 0);
                m_strobe_o = 1'b1;
                m_rw_o     = RW_WRITE;
                ctr_load   = 1'b1;
                state_d    = StWriteMem;
            end
            StWriteMem: begin
                busy_o = 1'b1;
                if (ctr_zero) begin
                    state_d = StWriteData;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StWriteData: begin
                busy_o  = 1'b1;
                rdy_o   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CACHE_STATS_EN
    // Index order: read hit, read miss, write hit, write miss.
    logic [STAT_W-1:0] stat_q [4];
    logic [STAT_W-1:0] stat_d [4];
    logic [3:0]        stat_inc;

    assign stat_inc[0] = (state_q == StRead) & hit;
    assign stat_inc[1] = (state_q == StRead) & ~hit;
    assign stat_inc[2] = (state_q == StWrite) & hit;
    assign stat_inc[3] = (state_q == StWrite) & ~hit;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr_i) begin
                stat_d[i] = '0;
            end else if (stat_inc[i] && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) stat_q[i] <= stat_d[i];
        end
    end

    assign rd_hit_cnt_o  = stat_q[0];
    assign rd_miss_cnt_o = stat_q[1];
    assign wr_hit_cnt_o  = stat_q[2];
    assign wr_miss_cnt_o = stat_q[3];
`endif

endmodule
